hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide engine that writes the Hi/Lo pair. Sits beside the EX stage and
//  drives the decode stage's Hi/Lo update port (newHi, newLo, HiLoWrite).
//  Accepts one MULT/MULTU/DIV/DIVU per Start pulse and iterates one bit per cycle.
//  Raises Busy so the hazard logic stalls any MFHI/MFLO or new mul/div until the result lands.
// PARAMETERS
//  WIDTH    32  operand width; Hi/Lo are each WIDTH bits
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Reset      in   1      asynchronous, active-high reset
//  Start      in   1      request; sampled only in IDLE
//  Op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  A          in   WIDTH  rs operand (multiplicand / dividend)
//  B          in   WIDTH  rt operand (multiplier / divisor)
//  Abort      in   1      pipeline flush; cancels the op in flight
//  Busy       out  1      high in RUN and DONE
//  HiLoWrite  out  1      one-cycle write strobe to decode-stage Hi/Lo
//  newHi      out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  newLo      out  WIDTH  MULT: product[W-1:0];  DIV: quotient
//  DivByZero  out  1      pulses with HiLoWrite when a DIV/DIVU had B==0
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0, Busy=0, HiLoWrite=0, DivByZero=0, newHi=newLo=0.
//  States:
//   IDLE: on Start=1 && Abort=0, latch Op, |A|, |B| (MULTU/DIVU take raw values),
//         sign flags sA=A[W-1], sB=B[W-1] (signed ops only), counter=0, go RUN.
//         Start is ignored in every other state.
//   RUN:  exactly WIDTH cycles, counter 0..WIDTH-1.
//         MUL: shift-add on a 2W accumulator; add |A| when the current multiplier LSB is 1.
//         DIV: restoring divide; shift {rem,quot} left 1, trial-subtract |B|; keep if no borrow,
//              set quot LSB=1.
//         After counter==WIDTH-1, go DONE.
//   DONE: one cycle, then IDLE.
//         HiLoWrite=1; newHi/newLo hold the sign-corrected result.
//         MULT: negate the 2W product when sA^sB.
//         DIV:  negate the quotient when sA^sB; the remainder takes sign sA.
//  Outputs are registered. Latency: Start accepted at edge E -> HiLoWrite high in the cycle
//  after edge E+WIDTH+1 (33 cycles for WIDTH=32), fixed for every op and operand value.
//  newHi/newLo hold their last value outside DONE. Consumers qualify them only with HiLoWrite.
//  Divide by zero: the full iteration still runs. Result Hi=A (original), Lo={WIDTH{1'b1}},
//   DivByZero=1 in DONE.
//  Signed overflow (DIV -2^(W-1) / -1): Lo=32'h80000000, Hi=0. No flag.
//  Abort=1 in RUN or DONE: next state IDLE, HiLoWrite forced 0 that cycle.
//   Busy drops the next cycle. Hi/Lo are not written.
//  Abort and Start together in IDLE: Abort wins, nothing is accepted.
//  Reset mid-RUN: immediate return to IDLE. No HiLoWrite is emitted.
//  Back-to-back: a Start in the cycle after DONE (state IDLE) is accepted normally.
// TESTING
//  1. MULTU A=32'hFFFFFFFF B=32'h2 -> after 33 cycles HiLoWrite=1, Hi=1, Lo=32'hFFFFFFFE.
//  2. MULT A=-3 B=7 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB; Busy high exactly 33 cycles.
//  3. DIV A=-7 B=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1); DIVU 100/7 -> Lo=14, Hi=2.
//  4. DIVU A=5 B=0 -> Hi=5, Lo=32'hFFFFFFFF, DivByZero=1 for the HiLoWrite cycle only.
//  5. Start MULT, Abort at counter=10 -> no HiLoWrite. Busy=0 next cycle.
//     A new Start after that is accepted with full latency.
//  6. Assert Reset at counter=20 -> all outputs 0 immediately; Start while Busy=1 has no effect.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing the Hi/Lo write-back pair.
// One bit per cycle: shift-add multiply, restoring divide, sign fix-up at the end.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             HiLoWrite,
    output logic [WIDTH-1:0] newHi,
    output logic [WIDTH-1:0] newLo,
    output logic             DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a_orig;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_hlw;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_part;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_c;
    logic [WIDTH-1:0]   w_quot_c;
    logic [WIDTH-1:0]   w_rem_c;
    logic               w_bz;

    // Op[0] set means unsigned: operands are taken raw.
    assign w_neg_a = ~Op[0] & A[WIDTH-1];
    assign w_neg_b = ~Op[0] & B[WIDTH-1];
    assign w_abs_a = w_neg_a ? -A : A;
    assign w_abs_b = w_neg_b ? -B : B;

    // Multiplier sits in the low half and is consumed from bit 0.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder needs one guard bit after the left shift.
    assign w_div_part  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_part - {1'b0, r_b};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0]
                                  : w_div_part[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

    assign w_prod_c = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot_c = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0]
                                    : r_acc[WIDTH-1:0];
    assign w_rem_c  = r_sa ? -r_acc[2*WIDTH-1:WIDTH]
                           : r_acc[2*WIDTH-1:WIDTH];
    assign w_bz     = (r_b == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_orig <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_hlw    <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_hlw <= 1'b0;
            r_dbz <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (Start && !Abort) begin
                        r_div    <= Op[1];
                        r_sa     <= w_neg_a;
                        r_sb     <= w_neg_b;
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_a_orig <= A;
                        r_acc    <= Op[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                          : {{WIDTH{1'b0}}, w_abs_b};
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_busy <= 1'b1;
                        r_acc  <= r_div ? w_div_next : w_mul_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (Abort) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_busy <= 1'b1;
                        r_hlw  <= 1'b1;
                        if (!r_div) begin
                            r_hi <= w_prod_c[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_c[WIDTH-1:0];
                        end else if (w_bz) begin
                            r_hi  <= r_a_orig;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_rem_c;
                            r_lo <= w_quot_c;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign HiLoWrite = r_hlw;
    assign DivByZero = r_dbz;
    assign newHi     = r_hi;
    assign newLo     = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an
// arithmetic reference model (64-bit products, native / and %).
module tb_hilo_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Abort;
    logic        Busy;
    logic        HiLoWrite;
    logic [31:0] newHi;
    logic [31:0] newLo;
    logic        DivByZero;

    int n_err;
    int n_chk;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Abort     (Abort),
        .Busy      (Busy),
        .HiLoWrite (HiLoWrite),
        .newHi     (newHi),
        .newLo     (newLo),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] hi,
                                      output logic [31:0] lo,
                                      output logic dbz);
        longint          p;
        longint unsigned pu;
        int              sa;
        int              sb;
        dbz = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin
                p  = longint'(sa) * longint'(sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                pu = {32'd0, a} * {32'd0, b};
                hi = pu[63:32];
                lo = pu[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi  = a;
                    lo  = 32'hFFFFFFFF;
                    dbz = 1'b1;
                end else if (op == 2'b11) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
        endcase
    endfunction

    // Called at a negedge, n_start posedges after the accepting edge.
    task automatic collect(input int n_start, input int bc_start,
                           input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        int          n;
        int          bc;
        ref_model(op, a, b, eh, el, ed);
        n  = n_start;
        bc = bc_start;
        while (!HiLoWrite && n < 50) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (Busy) bc++;
        end
        chk("latency", n, 33);
        if (bc_start >= 0) chk("busy_cycles", bc, 33);
        chk("hi", newHi, eh);
        chk("lo", newLo, el);
        chk("divbyzero", DivByZero, ed);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        issue(op, a, b);
        @(negedge Clk);
        collect(0, Busy ? 1 : 0, op, a, b);
    endtask

    task automatic after_done();
        @(negedge Clk);
        chk("strobe_drop", HiLoWrite, 0);
        chk("dbz_drop", DivByZero, 0);
        chk("busy_drop", Busy, 0);
    endtask

    task automatic quiet(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            @(negedge Clk);
            if (HiLoWrite) hits++;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'd0;
        sp[1] = 32'd1;
        sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h80000000;
        sp[4] = 32'h7FFFFFFF;
        case ($urandom_range(0, 3))
            0:       return sp[$urandom_range(0, 4)];
            1:       return $urandom_range(0, 100);
            2:       return -$urandom_range(1, 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          hits;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_err = 0;
        n_chk = 0;
        Reset = 1'b1;
        Start = 1'b0;
        Abort = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_hlw", HiLoWrite, 0);
        chk("rst_hi", newHi, 0);
        chk("rst_lo", newLo, 0);
        chk("rst_dbz", DivByZero, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run_op(2'b01, 32'hFFFFFFFF, 32'h2);
        run_op(2'b00, -32'sd3, 32'd7);
        run_op(2'b10, -32'sd7, 32'd2);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b11, 32'd5, 32'd0);
        after_done();
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b10, -32'sd9, 32'd0);
        after_done();

        issue(2'b00, 32'd123, 32'd456);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        @(negedge Clk);
        chk("abort_busy", Busy, 0);
        quiet(40, hits);
        chk("abort_no_write", hits, 0);
        run_op(2'b00, 32'd123, 32'd456);
        after_done();

        Start = 1'b1;
        Abort = 1'b1;
        Op    = 2'b01;
        A     = 32'd3;
        B     = 32'd3;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Abort = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_start_busy", Busy, 0);
        quiet(40, hits);
        chk("abort_start_no_write", hits, 0);

        issue(2'b01, 32'd6, 32'd7);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1;
        Op    = 2'b11;
        A     = 32'd100;
        B     = 32'd3;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        collect(6, -1, 2'b01, 32'd6, 32'd7);
        after_done();

        issue(2'b10, -32'sd1000, 32'd13);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_hlw", HiLoWrite, 0);
        chk("mid_rst_hi", newHi, 0);
        chk("mid_rst_lo", newLo, 0);
        @(negedge Clk);
        Reset = 1'b0;
        quiet(40, hits);
        chk("mid_rst_no_write", hits, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb);
        end
        after_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
